cluster_pwr_seq: RTL

Sequences cluster power-up and power-down. It sits between the SoC control register block and the cluster power domain. It converts a level request (cluster on/off, fetch enable) into an ordered, timed sequence on cluster power, bypass, clock enable, reset and fetch enable. It handshakes with the PMU power switch and reports its state back for readout.

---
 rtl/cluster_pwr_seq_pkg.sv | 44 ++++
 rtl/cluster_pwr_seq_cnt.sv | 29 ++
 rtl/cluster_pwr_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types for the cluster power sequencer: state encoding, rail bundle
// and the per-state rail decode used by the top.
package cluster_pwr_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    OFF        = 4'd0,
    PWR_UP     = 4'd1,
    CLK_WAIT   = 4'd2,
    RST_REL    = 4'd3,
    ON         = 4'd4,
    STOP       = 4'd5,
    RST_ASSERT = 4'd6,
    PWR_DOWN   = 4'd7,
    ERR        = 4'd8
  } cluster_pwr_state_e;

  typedef struct packed {
    logic pow;
    logic byp;
    logic clk_en;
    logic rstn;
  } rail_t;

  localparam rail_t RAIL_RESET = '{pow: 1'b0, byp: 1'b1, clk_en: 1'b0, rstn: 1'b0};

  function automatic rail_t rail_of(input cluster_pwr_state_e s);
    rail_t r;
    r = RAIL_RESET;
    case (s)
      PWR_UP, RST_ASSERT: r = '{pow: 1'b1, byp: 1'b1, clk_en: 1'b0, rstn: 1'b0};
      CLK_WAIT:           r = '{pow: 1'b1, byp: 1'b0, clk_en: 1'b1, rstn: 1'b0};
      RST_REL, ON, STOP:  r = '{pow: 1'b1, byp: 1'b0, clk_en: 1'b1, rstn: 1'b1};
      default:            r = RAIL_RESET;
    endcase
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cluster_pwr_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module cluster_pwr_seq_cnt #(
  parameter int W = 4
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power-up/power-down sequencer with PMU ack handshake.
// Optional ack timeout to ERR is enabled by defining CLUSTER_PWR_SEQ_TIMEOUT_EN.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int CLK_WAIT_CYCLES    = 4,
  parameter int RST_WAIT_CYCLES    = 8,
  parameter int DRAIN_CYCLES       = 16,
  parameter int ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               pow_req_i,
  input  logic               fetch_req_i,
  input  logic               pwr_ack_i,
  output logic               cluster_pow_o,
  output logic               cluster_byp_o,
  output logic               cluster_clk_en_o,
  output logic               cluster_rstn_o,
  output logic               cluster_fetch_enable_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] state_o,
  output logic               irq_o,
  output logic               err_o
);

  localparam int DWELL_MAX = max_int(max_int(CLK_WAIT_CYCLES, RST_WAIT_CYCLES), DRAIN_CYCLES);
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

  cluster_pwr_state_e state_q, state_n;
  rail_t              rail_q, rail_d;
  logic               fetch_q, fetch_d;
  logic               busy_q, busy_d;
  logic               irq_q, irq_d;
  logic               err_q, err_d;

  logic               dwell_load;
  logic [DWELL_W-1:0] dwell_load_val;
  logic               dwell_zero;
  logic               ack_timeout;
  logic               state_change;

  assign state_change = (state_n != state_q);
  assign dwell_load   = state_change;

  always_comb begin
    dwell_load_val = '0;
    case (state_n)
      CLK_WAIT:            dwell_load_val = DWELL_W'(CLK_WAIT_CYCLES - 1);
      RST_REL, RST_ASSERT: dwell_load_val = DWELL_W'(RST_WAIT_CYCLES - 1);
      STOP:                dwell_load_val = DWELL_W'(DRAIN_CYCLES - 1);
      default:             dwell_load_val = '0;
    endcase
  end

  cluster_pwr_seq_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .load     (dwell_load),
    .load_val (dwell_load_val),
    .en       (1'b1),
    .zero     (dwell_zero)
  );

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT_CYCLES + 1);

  logic ack_wait;
  logic ack_load;
  logic ack_zero;

  assign ack_wait = (state_q == PWR_UP) || (state_q == PWR_DOWN);
  assign ack_load = state_change && ((state_n == PWR_UP) || (state_n == PWR_DOWN));

  cluster_pwr_seq_cnt #(.W(ACK_W)) u_ack_cnt (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .load     (ack_load),
    .load_val (ACK_W'(ACK_TIMEOUT_CYCLES - 1)),
    .en       (ack_wait),
    .zero     (ack_zero)
  );

  assign ack_timeout = ack_wait && ack_zero;
`else
  assign ack_timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    case (state_q)
      OFF:        if (pow_req_i)   state_n = PWR_UP;
      PWR_UP: begin
        if (pwr_ack_i)             state_n = CLK_WAIT;
        else if (ack_timeout)      state_n = ERR;
      end
      CLK_WAIT:   if (dwell_zero)  state_n = RST_REL;
      RST_REL:    if (dwell_zero)  state_n = ON;
      ON:         if (!pow_req_i)  state_n = STOP;
      STOP:       if (dwell_zero)  state_n = RST_ASSERT;
      RST_ASSERT: if (dwell_zero)  state_n = PWR_DOWN;
      PWR_DOWN: begin
        if (!pwr_ack_i)            state_n = OFF;
        else if (ack_timeout)      state_n = ERR;
      end
      ERR:        if (!pow_req_i)  state_n = OFF;
      default:                     state_n = OFF;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register instead of lagging it by a cycle.
  always_comb begin
    rail_d  = rail_of(state_n);
    fetch_d = (state_q == ON) && (state_n == ON) && fetch_req_i;
    busy_d  = !((state_n == OFF) || (state_n == ON));
    irq_d   = ((state_q == RST_REL) && (state_n == ON)) ||
              ((state_q == PWR_DOWN) && (state_n == OFF));
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    err_d   = err_q || (state_n == ERR);
`else
    err_d   = 1'b0;
`endif
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= OFF;
      rail_q  <= RAIL_RESET;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rail_q  <= rail_d;
      fetch_q <= fetch_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign cluster_pow_o          = rail_q.pow;
  assign cluster_byp_o          = rail_q.byp;
  assign cluster_clk_en_o       = rail_q.clk_en;
  assign cluster_rstn_o         = rail_q.rstn;
  assign cluster_fetch_enable_o = fetch_q;
  assign busy_o                 = busy_q;
  assign state_o                = state_q;
  assign irq_o                  = irq_q;
  assign err_o                  = err_q;

endmodule
